// File: rtl/mem_arbiter.sv
// Purpose : shares one memory port between fetch and data requesters (optional dbg port via MEM_ARB_DEBUG_PORT_EN).
// Latency : grant 1 cycle after req in IDLE; ack 1 cycle after mem_ready; abort after TIMEOUT_CYCLES BUSY cycles.
// Backpr. : requesters hold level req until their one-cycle ack; memory stalls via mem_ready, bounded by timeout.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ack,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ack,
`ifdef MEM_ARB_DEBUG_PORT_EN
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
`endif
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bus_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic [1:0] OWN_FETCH = 2'd0;
  localparam logic [1:0] OWN_DATA  = 2'd1;
  localparam logic [1:0] OWN_DBG   = 2'd2;

  // Last BUSY cycle index before the access is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state;
  logic [1:0]            owner;
  logic [7:0]            tcnt;

  logic                  grant_vld;
  logic [1:0]            grant_own;
  logic                  grant_we;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_wdata;

`ifdef MEM_ARB_DEBUG_PORT_EN
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt;
  logic       dbg_force;
  assign dbg_force = dbg_req && (starve_cnt >= STARVE_MAX);
`endif

  // Priority pick among the current requests: (starved dbg) > data > fetch (> dbg).
  always_comb begin
    grant_vld   = 1'b0;
    grant_own   = OWN_FETCH;
    grant_we    = 1'b0;
    grant_addr  = fetch_addr;
    grant_wdata = '0;
`ifdef MEM_ARB_DEBUG_PORT_EN
    if (dbg_force) begin
      grant_vld   = 1'b1;
      grant_own   = OWN_DBG;
      grant_we    = dbg_we;
      grant_addr  = dbg_addr;
      grant_wdata = dbg_wdata;
    end else
`endif
    if (data_req) begin
      grant_vld   = 1'b1;
      grant_own   = OWN_DATA;
      grant_we    = data_we;
      grant_addr  = data_addr;
      grant_wdata = data_wdata;
    end else if (fetch_req) begin
      grant_vld   = 1'b1;
      grant_own   = OWN_FETCH;
    end
`ifdef MEM_ARB_DEBUG_PORT_EN
    else if (dbg_req) begin
      grant_vld   = 1'b1;
      grant_own   = OWN_DBG;
      grant_we    = dbg_we;
      grant_addr  = dbg_addr;
      grant_wdata = dbg_wdata;
    end
`endif
  end

  // IDLE/BUSY/ACK sequencer: latch the winner, run the memory access, pulse the owner's ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_FETCH;
      tcnt      <= '0;
      fetch_ack <= 1'b0;
      data_ack  <= 1'b0;
`ifdef MEM_ARB_DEBUG_PORT_EN
      dbg_ack   <= 1'b0;
`endif
      rdata     <= '0;
      bus_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner     <= grant_own;
            mem_we    <= grant_we;
            mem_addr  <= grant_addr;
            mem_wdata <= grant_wdata;
            mem_en    <= 1'b1;
            tcnt      <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready && mem_en) begin
            if (!mem_we) rdata <= mem_rdata;
            mem_en <= 1'b0;
            fetch_ack <= (owner == OWN_FETCH);
            data_ack  <= (owner == OWN_DATA);
`ifdef MEM_ARB_DEBUG_PORT_EN
            dbg_ack   <= (owner == OWN_DBG);
`endif
            state <= ACK;
          end else if (tcnt == TMO_LAST) begin
            rdata   <= '0;
            bus_err <= 1'b1;
            mem_en  <= 1'b0;
            fetch_ack <= (owner == OWN_FETCH);
            data_ack  <= (owner == OWN_DATA);
`ifdef MEM_ARB_DEBUG_PORT_EN
            dbg_ack   <= (owner == OWN_DBG);
`endif
            state <= ACK;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        ACK: begin
          fetch_ack <= 1'b0;
          data_ack  <= 1'b0;
`ifdef MEM_ARB_DEBUG_PORT_EN
          dbg_ack   <= 1'b0;
`endif
          bus_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_DEBUG_PORT_EN
  // Count grants dbg loses while requesting; clear once dbg is served.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE && grant_vld) begin
      if (grant_own == OWN_DBG)
        starve_cnt <= '0;
      else if (dbg_req)
        starve_cnt <= starve_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed checks of mem_arbiter grant, ack, timeout, reset and latching behaviour.
// Latency : inputs driven 1ns after posedge, outputs sampled 1ns after posedge.
// Backpr. : requesters drop req after seeing their ack, as the arbiter expects.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic        data_req;
  logic        data_we;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;
  logic        data_ack;
`ifdef MEM_ARB_DEBUG_PORT_EN
  logic        dbg_req;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_ack;
`endif
  logic [15:0] rdata;
  logic        bus_err;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int errors = 0;
  int checks = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack),
`ifdef MEM_ARB_DEBUG_PORT_EN
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
`endif
    .rdata(rdata), .bus_err(bus_err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({fetch_ack, data_ack, bus_err, mem_en, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
      errors++; $display("FAIL reset_outputs: got ack=%b/%b err=%b en=%b we=%b addr=%h wd=%h rd=%h want all 0",
                         fetch_ack, data_ack, bus_err, mem_en, mem_we, mem_addr, mem_wdata, rdata);
    end
    reset = 1'b0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0070;
    tick();
    checks++;
    if (mem_en !== 1'b1) begin errors++; $display("FAIL reset_pre_grant: mem_en=%b want 1", mem_en); end
    reset = 1'b1;
    tick();
    checks++;
    if (mem_en !== 1'b0 || data_ack !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL reset_mid_busy: en=%b ack=%b err=%b want 0 0 0", mem_en, data_ack, bus_err);
    end
    tick();
    reset = 1'b0; data_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_en !== 1'b0 || data_ack !== 1'b0 || bus_err !== 1'b0 || mem_addr !== 16'h0000) begin
        errors++; $display("FAIL reset_after_release: en=%b ack=%b err=%b addr=%h want 0 0 0 0000",
                           mem_en, data_ack, bus_err, mem_addr);
      end
    end
  endtask

  task automatic test_fetch_read();
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010 || fetch_ack !== 1'b0) begin
      errors++; $display("FAIL fetch_grant: en=%b we=%b addr=%h ack=%b want 1 0 0010 0", mem_en, mem_we, mem_addr, fetch_ack);
    end
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    checks++;
    if (fetch_ack !== 1'b1 || data_ack !== 1'b0 || bus_err !== 1'b0 || rdata !== 16'hBEEF || mem_en !== 1'b0) begin
      errors++; $display("FAIL fetch_ack: ack=%b dack=%b err=%b rdata=%h en=%b want 1 0 0 beef 0",
                         fetch_ack, data_ack, bus_err, rdata, mem_en);
    end
    fetch_req = 1'b0; mem_ready = 1'b0;
    tick();
    checks++;
    if (fetch_ack !== 1'b0 || rdata !== 16'hBEEF) begin
      errors++; $display("FAIL fetch_ack_pulse: ack=%b rdata=%h want 0 beef", fetch_ack, rdata);
    end
  endtask

  task automatic test_priority_write();
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0020; data_wdata = 16'h1234;
    fetch_req = 1'b1; fetch_addr = 16'h0050;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin
      errors++; $display("FAIL prio_data_grant: en=%b we=%b addr=%h wd=%h want 1 1 0020 1234", mem_en, mem_we, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1; mem_rdata = 16'hAAAA;
    tick();
    checks++;
    if (data_ack !== 1'b1 || fetch_ack !== 1'b0 || rdata !== 16'hBEEF) begin
      errors++; $display("FAIL prio_data_ack: dack=%b fack=%b rdata=%h want 1 0 beef", data_ack, fetch_ack, rdata);
    end
    data_req = 1'b0; mem_ready = 1'b0;
    tick();
    checks++;
    if (mem_en !== 1'b0 || data_ack !== 1'b0) begin
      errors++; $display("FAIL prio_idle_gap: en=%b dack=%b want 0 0", mem_en, data_ack);
    end
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0050) begin
      errors++; $display("FAIL prio_fetch_next: en=%b we=%b addr=%h want 1 0 0050", mem_en, mem_we, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 16'h5555;
    tick();
    checks++;
    if (fetch_ack !== 1'b1 || data_ack !== 1'b0 || rdata !== 16'h5555) begin
      errors++; $display("FAIL prio_fetch_ack: fack=%b dack=%b rdata=%h want 1 0 5555", fetch_ack, data_ack, rdata);
    end
    fetch_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0060;
    tick();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (data_ack === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n != 15) begin errors++; $display("FAIL timeout_cycles: ack after %0d BUSY cycles want 15", n); end
    checks++;
    if (bus_err !== 1'b1 || rdata !== 16'h0000 || mem_en !== 1'b0) begin
      errors++; $display("FAIL timeout_err: err=%b rdata=%h en=%b want 1 0000 0", bus_err, rdata, mem_en);
    end
    data_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 16'h9999;
    tick(); tick(); tick();
    checks++;
    if (bus_err !== 1'b0 || data_ack !== 1'b0 || fetch_ack !== 1'b0 || mem_en !== 1'b0 || rdata !== 16'h0000) begin
      errors++; $display("FAIL idle_ready_ignored: err=%b dack=%b fack=%b en=%b rdata=%h want 0 0 0 0 0000",
                         bus_err, data_ack, fetch_ack, mem_en, rdata);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_addr_latch();
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0030;
    tick();
    data_addr = 16'h0040; data_we = 1'b1; data_wdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_addr !== 16'h0030 || mem_we !== 1'b0 || mem_en !== 1'b1) begin
        errors++; $display("FAIL latch_busy: addr=%h we=%b en=%b want 0030 0 1", mem_addr, mem_we, mem_en);
      end
    end
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    tick();
    checks++;
    if (data_ack !== 1'b1 || mem_addr !== 16'h0030 || rdata !== 16'h7777) begin
      errors++; $display("FAIL latch_ack: dack=%b addr=%h rdata=%h want 1 0030 7777", data_ack, mem_addr, rdata);
    end
    data_req = 1'b0; data_we = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

`ifdef MEM_ARB_DEBUG_PORT_EN
  task automatic test_dbg_starve();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0099;
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h00A0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      checks++;
      if (mem_addr !== ((n < 5) ? 16'h00A0 : 16'h0099) || mem_en !== 1'b1) begin
        errors++; $display("FAIL dbg_grant_%0d: addr=%h en=%b want %h 1", n, mem_addr, mem_en,
                           (n < 5) ? 16'h00A0 : 16'h0099);
      end
      mem_ready = 1'b1; mem_rdata = 16'h1000 + 16'(n);
      tick();
      checks++;
      if (dbg_ack !== (n == 5) || data_ack !== (n < 5)) begin
        errors++; $display("FAIL dbg_ack_%0d: dbg_ack=%b data_ack=%b want %b %b", n, dbg_ack, data_ack, n == 5, n < 5);
      end
      mem_ready = 1'b0;
      if (n == 5) dbg_req = 1'b0;
      tick();
    end
    data_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
`ifdef MEM_ARB_DEBUG_PORT_EN
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
`endif
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_fetch_read();
    test_priority_write();
    test_timeout();
    test_addr_latch();
`ifdef MEM_ARB_DEBUG_PORT_EN
    test_dbg_starve();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
